instr_fetch_seq: RTL and testbench
==================================

Name: instr_fetch_seq

Overview:
Instruction-fetch sequencer for the single-cycle MIPS datapath. It owns the PC and fetches words from instruction memory over a req/ack handshake. It presents each instruction, with its opcode field, to the main control decoder and datapath through a valid/ready handshake. It takes back the decoder's Jump and Branch outputs, plus the ALU Zero flag, to select the next PC.

Parameters:
ADDR_W, 32, PC and instruction-memory address width (>= 28)
RESET_PC, 32'h0000_0000, PC loaded on reset; word aligned; bits above ADDR_W ignored

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request; held until imem_ack
imem_addr  out  ADDR_W  fetch address (= pc_out); bits [1:0] always 0
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  instruction word, valid when imem_ack=1
instr  out  32  registered current instruction
opcode  out  6  instr[31:26]; feeds the control decoder
instr_valid  out  1  instr/opcode valid for the datapath
instr_ready  in  1  datapath accepts the instruction; Jump/Branch/Zero are valid this cycle
Jump  in  1  from the control decoder
Branch  in  1  from the control decoder
Zero  in  1  from the ALU
pc_out  out  ADDR_W  PC of the current instruction
pc_plus4  out  ADDR_W  pc_out + 4, modulo 2^ADDR_W

Behaviour:
- FSM states: IDLE, FETCH, ISSUE.
- Reset (rst=1 at an edge) forces state=IDLE, pc=RESET_PC, instr=0, instr_valid=0. Consequently imem_req=0 and opcode=0.
- Reset takes priority over every other event. If rst asserts during FETCH, the outstanding request is abandoned. An ack that arrives after reset is ignored.
- IDLE: imem_req=0. Moves to FETCH on the next cycle unconditionally.
- FETCH: imem_req=1, imem_addr=pc. The address is stable until ack. The wait time is unbounded.
  - If imem_ack=1, latch imem_rdata into instr, set instr_valid=1, and go to ISSUE.
  - An ack in the same cycle the request is first raised is legal.
- ISSUE: imem_req=0 and instr_valid=1. instr, opcode and pc_out are held stable until instr_ready=1.
  - On instr_valid & instr_ready, load the next pc, clear instr_valid, and go to FETCH.
  - imem_ack seen in IDLE or ISSUE is ignored.
- Next PC is computed in the accept cycle. Priority order:
  - Jump=1: {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00}. Jump beats Branch.
  - Branch=1 and Zero=1: pc_plus4 + (sign-extended instr[15:0] << 2), modulo 2^ADDR_W.
  - Otherwise: pc_plus4.
  - All arithmetic wraps silently. PC bits [1:0] are forced to 0.
- Jump, Branch and Zero are sampled only in the accept cycle and are don't-care at all other times.
- Throughput: at least 2 cycles per instruction (FETCH with immediate ack, then ISSUE with immediate ready). There is no branch delay slot.
- pc_plus4 is combinational from pc. All other outputs are registered or decoded from state.

Optional Feature:
FETCH_CNT_EN:
- Defined: adds port fetch_count (out, 32). It counts accepted instructions (instr_valid & instr_ready), resets to 0 with rst, and wraps from 32'hFFFF_FFFF to 0.
- Undefined: the port and the counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then straight-line code: rst for 2 cycles, RESET_PC=0, memory acks immediately, instr_ready=1, Jump=Branch=0 -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid high every 2nd cycle; opcode equals imem_rdata[31:26].
- Jump: at pc=0x0040_0010, instr=32'h0810_0000 (j), Jump=1 at accept -> next imem_addr=0x0040_0000. Assert Branch=1, Zero=1 simultaneously -> still 0x0040_0000.
- Branch: pc=0x20, instr imm=16'hFFFE, Branch=1. With Zero=1 -> next addr 0x1C. With Zero=0 -> next addr 0x24.
- Memory wait and stall: imem_ack delayed 5 cycles -> imem_req/imem_addr held constant for 5 cycles. Then instr_ready held low 3 cycles -> instr/opcode/pc_out unchanged and no new req.
- Reset mid-fetch: rst asserted during FETCH with ack pending, ack arrives 1 cycle after rst deasserts (state IDLE) -> ack ignored, instr_valid=0, next request at RESET_PC.
- Wrap, plus counter under FETCH_CNT_EN: ADDR_W=32, pc=0xFFFF_FFFC, no branch -> next addr 0x0000_0000. fetch_count preloaded via 2^32-1 accepts (or forced) wraps to 0. Counter absent when macro undefined.

Source files
------------

// File: rtl/instr_fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, fetches over imem req/ack, issues via valid/ready.
// Optional FETCH_CNT_EN adds a 32-bit accepted-instruction counter on port fetch_count.
module instr_fetch_seq #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              Jump,
  input  logic              Branch,
  input  logic              Zero,
  output logic [ADDR_W-1:0] pc_out,
`ifdef FETCH_CNT_EN
  output logic [31:0]       fetch_count,
`endif
  output logic [ADDR_W-1:0] pc_plus4
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] RST_PC     = ADDR_W'(RESET_PC) & ALIGN_MASK;
  // Jump keeps only the PC bits above the 28-bit region addressed by the target field
  localparam logic [ADDR_W-1:0] JMP_HI_MASK = {ADDR_W{1'b1}} << 28;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] next_pc;

  assign pc_plus4  = pc + ADDR_W'(4);
  assign pc_out    = pc;
  assign imem_addr = pc;
  assign imem_req  = (state == FETCH);
  assign opcode    = instr[31:26];

  always_comb begin
    jump_tgt = (pc_plus4 & JMP_HI_MASK) | ADDR_W'({instr[25:0], 2'b00});
    br_off   = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
    next_pc  = pc_plus4;
    if (Jump)
      next_pc = jump_tgt;
    else if (Branch && Zero)
      next_pc = pc_plus4 + br_off;
    next_pc = next_pc & ALIGN_MASK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RST_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        default: begin
          state       <= IDLE;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      fetch_count <= '0;
    else if (instr_valid && instr_ready)
      fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: expected fetch addresses are queued when an
// instruction is accepted and checked when the next request appears.
module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        instr_ready;
  logic        Jump, Branch, Zero;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
`ifdef FETCH_CNT_EN
  logic [31:0] fetch_count;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned accepts = 0;
  logic [31:0] sb[$];

  instr_fetch_seq #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .Jump(Jump), .Branch(Branch), .Zero(Zero),
    .pc_out(pc_out),
`ifdef FETCH_CNT_EN
    .fetch_count(fetch_count),
`endif
    .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_count();
`ifdef FETCH_CNT_EN
    check("fetch_count", fetch_count, accepts);
`endif
  endtask

  // Wait for a request and compare its address against the scoreboard head.
  task automatic expect_req(output logic [31:0] addr);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", {31'd0, imem_req}, 32'd1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
      addr = 'x;
    end else begin
      addr = sb.pop_front();
      check("imem_addr", imem_addr, addr);
      check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
    end
  endtask

  task automatic do_instr(input logic [31:0] w, input int ack_dly, input int rdy_dly,
                          input logic j, input logic b, input logic z,
                          input logic [31:0] exp_next);
    logic [31:0] addr;
    expect_req(addr);
    for (int i = 0; i < ack_dly; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      tick();
      check("req_held", {31'd0, imem_req}, 32'd1);
      check("addr_held", imem_addr, addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = w;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check("valid_up", {31'd0, instr_valid}, 32'd1);
    check("instr", instr, w);
    check("opcode", {26'd0, opcode}, {26'd0, w[31:26]});
    check("pc_out", pc_out, addr);
    check("pc_plus4", pc_plus4, addr + 32'd4);
    check("req_low_issue", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < rdy_dly; i++) begin
      instr_ready = 1'b0;
      imem_ack    = 1'b1;
      Jump        = 1'($urandom);
      Branch      = 1'($urandom);
      Zero        = 1'($urandom);
      tick();
      check("stall_instr", instr, w);
      check("stall_pc", pc_out, addr);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_noreq", {31'd0, imem_req}, 32'd0);
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    Jump        = j;
    Branch      = b;
    Zero        = z;
    sb.push_back(exp_next);
    tick();
    accepts++;
    instr_ready = 1'b0;
    Jump        = 1'b0;
    Branch      = 1'b0;
    Zero        = 1'b0;
    check("valid_down", {31'd0, instr_valid}, 32'd0);
    check_count();
  endtask

  initial begin
    logic [31:0] addr;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
    tick();
    tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_opcode", {26'd0, opcode}, 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check_count();
    rst = 1'b0;
    sb.push_back(32'h0000_0000);

    do_instr(32'h2008_0001, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
    do_instr(32'h2009_0002, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0008);
    do_instr(32'h0810_0004, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0040_0010);
    do_instr(32'h0810_0000, 0, 0, 1'b1, 1'b1, 1'b1, 32'h0040_0000);
    do_instr(32'h0800_0008, 5, 3, 1'b1, 1'b0, 1'b0, 32'h0000_0020);
    do_instr(32'h1000_FFFE, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_001C);
    do_instr(32'h0000_0000, 2, 1, 1'b0, 1'b0, 1'b0, 32'h0000_0020);
    do_instr(32'h1000_FFFE, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0024);

    // Reset while a fetch is outstanding; a late ack in IDLE must be ignored.
    expect_req(addr);
    rst = 1'b1;
    tick();
    tick();
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    rst        = 1'b0;
    accepts    = 0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack   = 1'b0;
    check("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    check("late_ack_instr", instr, 32'd0);
    check_count();
    sb.push_back(32'h0000_0000);

    do_instr(32'h1000_FFFE, 0, 0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    do_instr(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    expect_req(addr);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
